// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the RV32I pipeline stall/flush
//               controller: address width, zero word and controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int ADDR_LEN = 32;
  localparam logic [ADDR_LEN-1:0] ZERO_WORD = '0;

  // RUN: normal operation. WAIT_FETCH: a taken branch is parked until the
  // in-flight fetch completes and can be thrown away.
  typedef enum logic [0:0] {
    PC_RUN        = 1'b0,
    PC_WAIT_FETCH = 1'b1
  } pc_state_e;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_perf_cnt
// Description : Stall-cycle and redirect counters for the pipeline controller.
//               Both counters advance only on ready cycles and wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_perf_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int CntLen = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rdy,
  input  logic              i_stall_inc,
  input  logic              i_flush_inc,
  output logic [CntLen-1:0] o_stall_cycles,
  output logic [CntLen-1:0] o_flush_count
);

  logic [CntLen-1:0] r_stall_cycles;
  logic [CntLen-1:0] r_flush_count;

  // Count stall cycles and issued redirects, frozen while the pipe is not ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (i_rdy) begin
      if (i_stall_inc) r_stall_cycles <= r_stall_cycles + CntLen'(1);
      if (i_flush_inc) r_flush_count  <= r_flush_count  + CntLen'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;

endmodule : pipe_ctrl_perf_cnt
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Central stall/flush controller for the 5-stage RV32I pipeline.
//               Arbitrates IF/ID/MEM stall requests against EX redirects and
//               parks a redirect while a fetch is still outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AddrLen = ADDR_LEN,
  parameter int CntLen  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               if_stall_req,
  input  logic               id_hazard_req,
  input  logic               mem_stall_req,
  input  logic               ex_jump,
  input  logic [AddrLen-1:0] ex_jump_target,
  output logic               pc_stall,
  output logic               if_id_stall,
  output logic               id_ex_stall,
  output logic               ex_mem_stall,
  output logic               mem_wb_bubble,
  output logic               id_stall,
  output logic               jump_or_not,
  output logic               pc_redirect,
  output logic [AddrLen-1:0] pc_redirect_target,
  output logic [CntLen-1:0]  stall_cycles,
  output logic [CntLen-1:0]  flush_count
);

  pc_state_e          r_state;
  pc_state_e          w_state_nxt;
  logic [AddrLen-1:0] r_pend_target;
  logic [AddrLen-1:0] w_pend_target_nxt;
  logic               w_flush_inc;
  logic               w_stall_any;

  // Controller state and parked redirect target; everything holds when not ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= PC_RUN;
      r_pend_target <= '0;
    end else if (rdy) begin
      r_state       <= w_state_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  // Priority arbitration of stall/flush controls and next-state selection
  always_comb begin
    pc_stall           = 1'b0;
    if_id_stall        = 1'b0;
    id_ex_stall        = 1'b0;
    ex_mem_stall       = 1'b0;
    mem_wb_bubble      = 1'b0;
    id_stall           = 1'b0;
    jump_or_not        = 1'b0;
    pc_redirect        = 1'b0;
    pc_redirect_target = '0;
    w_state_nxt        = r_state;
    w_pend_target_nxt  = r_pend_target;
    w_flush_inc        = 1'b0;

    if (rst) begin
      // Reset cycle: every control stays low.
    end else if (mem_stall_req) begin
      // Freeze everything up to EX; a pending ex_jump is preserved in EX.
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (r_state == PC_RUN && ex_jump) begin
      jump_or_not = 1'b1;
      if (!if_stall_req) begin
        pc_redirect        = 1'b1;
        pc_redirect_target = ex_jump_target;
        w_flush_inc        = 1'b1;
      end else begin
        // Fetch still busy: park the target and redirect once it lands.
        pc_stall          = 1'b1;
        w_pend_target_nxt = ex_jump_target;
        w_state_nxt       = PC_WAIT_FETCH;
      end
    end else if (r_state == PC_WAIT_FETCH) begin
      jump_or_not = 1'b1;
      if (if_stall_req) begin
        // Keep if_id empty and feed bubbles forward; EX holds no real work.
        pc_stall = 1'b1;
        id_stall = 1'b1;
      end else begin
        pc_redirect        = 1'b1;
        pc_redirect_target = r_pend_target;
        w_flush_inc        = 1'b1;
        w_state_nxt        = PC_RUN;
      end
    end else if (id_hazard_req || if_stall_req) begin
      // Load-use hazard and fetch stall both hold the front end and bubble ID.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_stall    = 1'b1;
    end
  end

  assign w_stall_any = pc_stall | if_id_stall | id_ex_stall | ex_mem_stall;

  pipe_ctrl_perf_cnt #(
    .CntLen (CntLen)
  ) u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .i_rdy          (rdy),
    .i_stall_inc    (w_stall_any),
    .i_flush_inc    (w_flush_inc),
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count)
  );

endmodule : pipe_ctrl
`default_nettype wire
